button_event_arbiter: RTL

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// Per-button press/long/repeat/release event generator with one pending slot per
// button and a round-robin arbitrated output register. Define BTN_AUTO_REPEAT_EN for auto-repeat.
module button_event_arbiter #(
  parameter int IDW      = 2,
  parameter int LONG_CYC = 50000000,
  parameter int REP_CYC  = 10000000,
  parameter int CNT_W    = 27
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2**IDW-1:0]   btn,
  input  logic                ev_ready,
  output logic                ev_valid,
  output logic [IDW-1:0]      ev_id,
  output logic [1:0]          ev_code,
  output logic [2**IDW-1:0]   held,
  output logic                overflow
);

  localparam int N       = 2**IDW;
  localparam int MAX_CYC = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_LONG    = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;
  localparam logic [1:0] EV_RELEASE = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
`endif

  // The counter must reach the larger of the two terminal counts.
  if (CNT_W < $clog2(MAX_CYC)) begin : g_cnt_w_too_small
    $error("button_event_arbiter: CNT_W cannot hold max(LONG_CYC, REP_CYC)");
  end

  typedef enum logic [1:0] {
    ST_UP   = 2'b00,
    ST_DOWN = 2'b01,
    ST_HELD = 2'b10
  } state_t;

  logic [N-1:0]     btn_q;
  state_t           state    [N];
  state_t           state_nx [N];
  logic [CNT_W-1:0] cnt      [N];
  logic [CNT_W-1:0] cnt_nx   [N];
  logic [N-1:0]     raise;
  logic [1:0]       raise_code [N];

  logic [N-1:0]     pend_v;
  logic [1:0]       pend_code [N];
  logic [IDW-1:0]   last_gnt;
  logic [IDW-1:0]   pick_id;
  logic             pick_found;
  logic             load;
  logic [N-1:0]     grant_vec;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_q <= '0;
      for (int i = 0; i < N; i++) begin
        state[i] <= ST_UP;
        cnt[i]   <= '0;
      end
    end else begin
      btn_q <= btn;
      for (int i = 0; i < N; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
    end
  end

  // Release is tested first in DOWN and HELD so it always beats a counter event.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_nx[i]   = state[i];
      cnt_nx[i]     = cnt[i];
      raise[i]      = 1'b0;
      raise_code[i] = EV_PRESS;
      case (state[i])
        ST_UP: begin
          if (btn_q[i]) begin
            state_nx[i]   = ST_DOWN;
            raise[i]      = 1'b1;
            raise_code[i] = EV_PRESS;
            cnt_nx[i]     = '0;
          end
        end
        ST_DOWN: begin
          if (!btn_q[i]) begin
            state_nx[i]   = ST_UP;
            raise[i]      = 1'b1;
            raise_code[i] = EV_RELEASE;
            cnt_nx[i]     = '0;
          end else if (cnt[i] == LONG_LAST) begin
            state_nx[i]   = ST_HELD;
            raise[i]      = 1'b1;
            raise_code[i] = EV_LONG;
            cnt_nx[i]     = '0;
          end else begin
            cnt_nx[i] = cnt[i] + 1'b1;
          end
        end
        ST_HELD: begin
          if (!btn_q[i]) begin
            state_nx[i]   = ST_UP;
            raise[i]      = 1'b1;
            raise_code[i] = EV_RELEASE;
            cnt_nx[i]     = '0;
`ifdef BTN_AUTO_REPEAT_EN
          end else if (cnt[i] == REP_LAST) begin
            raise[i]      = 1'b1;
            raise_code[i] = EV_REPEAT;
            cnt_nx[i]     = '0;
          end else begin
            cnt_nx[i] = cnt[i] + 1'b1;
          end
`else
          end else begin
            cnt_nx[i] = '0;
          end
`endif
        end
        default: begin
          state_nx[i] = ST_UP;
          cnt_nx[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      held[i] = (state[i] == ST_HELD);
    end
  end

  // Round-robin search starts one past the last granted index and wraps naturally.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = last_gnt;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && pend_v[last_gnt + IDW'(k)]) begin
        pick_found = 1'b1;
        pick_id    = last_gnt + IDW'(k);
      end
    end
  end

  assign load = !ev_valid || ev_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      grant_vec[i] = load && pick_found && (pick_id == IDW'(i));
    end
  end

  // A granted slot may be refilled on the same edge; only a full, ungranted slot drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_v   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N; i++) begin
        pend_code[i] <= EV_PRESS;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (raise[i]) begin
          if (pend_v[i] && !grant_vec[i]) begin
            overflow <= 1'b1;
          end else begin
            pend_v[i]    <= 1'b1;
            pend_code[i] <= raise_code[i];
          end
        end else if (grant_vec[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_code  <= EV_PRESS;
      last_gnt <= '1;
    end else if (load) begin
      if (pick_found) begin
        ev_valid <= 1'b1;
        ev_id    <= pick_id;
        ev_code  <= pend_code[pick_id];
        last_gnt <= pick_id;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule
